// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the operand fetch stage
//
// Purpose: datapath width, the architectural zero register index and the
// forwarding-source encoding used by fwd_mux.
package riscv_pkg;

  localparam int         XLEN     = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_src_e;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority bypass mux resolving one source operand
//
// Purpose: picks the youngest in-flight producer of a register, falling back
// to register-file data. Purely combinational.
// Ports:
//   i_sel                              source register index
//   i_rf_data                          register-file read data (pre-write)
//   i_ex_wen/i_ex_load/i_ex_rdsel/i_ex_data   EX producer
//   i_mem_wen/i_mem_rdsel/i_mem_data          MEM producer
//   i_wb_wen/i_wb_rdsel/i_wb_data             WB producer (also RF write port)
//   o_op                               resolved operand
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [4:0]      i_sel,
  input  logic [XLEN-1:0] i_rf_data,
  input  logic            i_ex_wen,
  input  logic            i_ex_load,
  input  logic [4:0]      i_ex_rdsel,
  input  logic [XLEN-1:0] i_ex_data,
  input  logic            i_mem_wen,
  input  logic [4:0]      i_mem_rdsel,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_wb_wen,
  input  logic [4:0]      i_wb_rdsel,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_op
);

  fwd_src_e w_src;

  // Youngest producer wins. A load in EX has no data yet, so it is skipped
  // here; the hazard logic in the parent holds the instruction until it
  // reaches MEM.
  always_comb begin
    w_src = FWD_RF;
    if (i_ex_wen && !i_ex_load && (i_ex_rdsel == i_sel)) begin
      w_src = FWD_EX;
    end else if (i_mem_wen && (i_mem_rdsel == i_sel)) begin
      w_src = FWD_MEM;
    end else if (i_wb_wen && (i_wb_rdsel == i_sel)) begin
      w_src = FWD_WB;
    end
  end

  // A zero select forces zero, which also stops any write to x0 from being
  // forwarded.
  always_comb begin
    o_op = i_rf_data;
    if (i_sel == REG_ZERO) begin
      o_op = '0;
    end else begin
      case (w_src)
        FWD_EX:  o_op = i_ex_data;
        FWD_MEM: o_op = i_mem_data;
        FWD_WB:  o_op = i_wb_data;
        default: o_op = i_rf_data;
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register read, bypass, load-use stall and ID/EX slot
//
// Purpose: reads both sources, forwards from EX/MEM/WB, stalls on load-use
// and registers the resolved instruction into the ID/EX slot.
// Ports:
//   clk, reset (sync, active-low)
//   in_*      decoded instruction with valid/ready handshake
//   rf_*      register-file read selects and returned data
//   ex_*/mem_*/wb_*  producer tuples for forwarding
//   flush     kills slot and incoming instruction
//   out_*     ID/EX slot with valid/ready handshake
//   stall_cnt saturating load-use stall cycle counter
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1sel,
  input  logic [4:0]      in_rs2sel,
  input  logic [4:0]      in_rdsel,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic            in_wen,
  input  logic            in_load,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1sel,
  output logic [4:0]      rf_rs2sel,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            ex_wen,
  input  logic            ex_load,
  input  logic [4:0]      ex_rdsel,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rdsel,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_enrd,
  input  logic [4:0]      wb_rdsel,
  input  logic [XLEN-1:0] wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rdsel,
  output logic            out_wen,
  output logic            out_load,
  output logic [XLEN-1:0] out_pc,
  output logic [CNTW-1:0] stall_cnt
);

  logic            r_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [4:0]      r_rdsel;
  logic            r_wen;
  logic            r_load;
  logic [XLEN-1:0] r_pc;
  logic [CNTW-1:0] r_stall_cnt;

  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_hz;
  logic            w_free;
  logic            w_accept;

  assign rf_rs1sel = in_rs1sel;
  assign rf_rs2sel = in_rs2sel;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .i_sel       (in_rs1sel),
    .i_rf_data   (rf_rs1),
    .i_ex_wen    (ex_wen),
    .i_ex_load   (ex_load),
    .i_ex_rdsel  (ex_rdsel),
    .i_ex_data   (ex_data),
    .i_mem_wen   (mem_wen),
    .i_mem_rdsel (mem_rdsel),
    .i_mem_data  (mem_data),
    .i_wb_wen    (wb_enrd),
    .i_wb_rdsel  (wb_rdsel),
    .i_wb_data   (wb_rd),
    .o_op        (w_op1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .i_sel       (in_rs2sel),
    .i_rf_data   (rf_rs2),
    .i_ex_wen    (ex_wen),
    .i_ex_load   (ex_load),
    .i_ex_rdsel  (ex_rdsel),
    .i_ex_data   (ex_data),
    .i_mem_wen   (mem_wen),
    .i_mem_rdsel (mem_rdsel),
    .i_mem_data  (mem_data),
    .i_wb_wen    (wb_enrd),
    .i_wb_rdsel  (wb_rdsel),
    .i_wb_data   (wb_rd),
    .o_op        (w_op2)
  );

  // Load-use: only sources the instruction actually reads can stall it.
  assign w_hz = in_valid && ex_wen && ex_load && (ex_rdsel != REG_ZERO) &&
                ((in_use_rs1 && (ex_rdsel == in_rs1sel)) ||
                 (in_use_rs2 && (ex_rdsel == in_rs2sel)));

  assign w_free   = !r_valid || out_ready;
  assign in_ready = w_free && !w_hz && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rdsel     <= '0;
      r_wen       <= 1'b0;
      r_load      <= 1'b0;
      r_pc        <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_op1   <= w_op1;
        r_op2   <= w_op2;
        r_rdsel <= in_rdsel;
        r_wen   <= in_wen;
        r_load  <= in_load;
        r_pc    <= in_pc;
      end else if (w_free) begin
        // Slot drained with nothing to replace it: bubble, fields hold.
        r_valid <= 1'b0;
      end

      // Only cycles where the stall is the sole reason for not accepting
      // are counted; backpressure and flush cycles are not.
      if (w_hz && w_free && !flush && (r_stall_cnt != {CNTW{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_op1   = r_op1;
  assign out_op2   = r_op2;
  assign out_rdsel = r_rdsel;
  assign out_wen   = r_wen;
  assign out_load  = r_load;
  assign out_pc    = r_pc;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed scoreboard bench for operand_fetch
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1sel, in_rs2sel, in_rdsel;
  logic        in_use_rs1, in_use_rs2, in_wen, in_load;
  logic [31:0] in_pc;
  logic [4:0]  rf_rs1sel, rf_rs2sel;
  logic [31:0] rf_rs1, rf_rs2;
  logic        ex_wen, ex_load;
  logic [4:0]  ex_rdsel;
  logic [31:0] ex_data;
  logic        mem_wen;
  logic [4:0]  mem_rdsel;
  logic [31:0] mem_data;
  logic        wb_enrd;
  logic [4:0]  wb_rdsel;
  logic [31:0] wb_rd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_pc;
  logic [4:0]  out_rdsel;
  logic        out_wen, out_load;
  logic [15:0] stall_cnt;

  logic [31:0] rf [32];

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        chk_op2;
    logic [4:0]  rdsel;
    logic        wen;
    logic        load;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  operand_fetch #(.XLEN(32), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1sel(in_rs1sel), .in_rs2sel(in_rs2sel), .in_rdsel(in_rdsel),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_wen(in_wen), .in_load(in_load), .in_pc(in_pc),
    .rf_rs1sel(rf_rs1sel), .rf_rs2sel(rf_rs2sel),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_rdsel(ex_rdsel), .ex_data(ex_data),
    .mem_wen(mem_wen), .mem_rdsel(mem_rdsel), .mem_data(mem_data),
    .wb_enrd(wb_enrd), .wb_rdsel(wb_rdsel), .wb_rd(wb_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rdsel(out_rdsel),
    .out_wen(out_wen), .out_load(out_load), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational register-file read model
  assign rf_rs1 = rf[rf_rs1sel];
  assign rf_rs2 = rf[rf_rs2sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic [31:0] pc);
    in_valid = v; in_rs1sel = rs1; in_rs2sel = rs2;
    in_use_rs1 = u1; in_use_rs2 = u2; in_rdsel = rd;
    in_wen = wen; in_load = ld; in_pc = pc;
  endtask

  task automatic push_exp(input logic [31:0] op1, input logic [31:0] op2, input logic c2,
                          input logic [4:0] rd, input logic wen, input logic ld,
                          input logic [31:0] pc);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.chk_op2 = c2; e.rdsel = rd;
    e.wen = wen; e.load = ld; e.pc = pc;
    sb.push_back(e);
  endtask

  // Settle, check in_ready, clock once, check out_valid and pop any
  // pending scoreboard entry produced by this edge.
  task automatic step(input string tag, input logic exp_ready, input logic exp_vld);
    exp_t e;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_vld});
    if (exp_vld && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".op1"}, out_op1, e.op1);
      if (e.chk_op2) chk({tag, ".op2"}, out_op2, e.op2);
      chk({tag, ".rdsel"}, {27'd0, out_rdsel}, {27'd0, e.rdsel});
      chk({tag, ".wen_load"}, {30'd0, out_wen, out_load}, {30'd0, e.wen, e.load});
      chk({tag, ".pc"}, out_pc, e.pc);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h0;
    rf[5] = 32'h1234;
    rf[7] = 32'hD;
    rf[3] = 32'h33;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    ex_wen = 0; ex_load = 0; ex_rdsel = 0; ex_data = 0;
    mem_wen = 0; mem_rdsel = 0; mem_data = 0;
    wb_enrd = 0; wb_rdsel = 0; wb_rd = 0;
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'h100);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.op1", out_op1, 32'd0);
    chk("rst.op2", out_op2, 32'd0);
    chk("rst.pc", out_pc, 32'd0);
    chk("rst.rdsel_wen_load", {25'd0, out_rdsel, out_wen, out_load}, 32'd0);
    chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b1;

    // Basic read; x0 source stays 0 despite WB writing x0
    wb_enrd = 1; wb_rdsel = 5'd0; wb_rd = 32'hFFFF;
    chk("rf_rs1sel", {27'd0, rf_rs1sel}, 32'd5);
    push_exp(32'h1234, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, 32'h100);
    step("basic", 1'b1, 1'b1);
    wb_enrd = 0;

    // Forward priority on x7
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 32'h104);
    ex_wen = 1; ex_rdsel = 5'd7; ex_data = 32'hA;
    mem_wen = 1; mem_rdsel = 5'd7; mem_data = 32'hB;
    wb_enrd = 1; wb_rdsel = 5'd7; wb_rd = 32'hC;
    push_exp(32'hA, 32'h0, 1'b1, 5'd10, 1'b1, 1'b0, 32'h104);
    step("fwd_ex", 1'b1, 1'b1);
    ex_wen = 0; in_pc = 32'h108;
    push_exp(32'hB, 32'h0, 1'b1, 5'd10, 1'b1, 1'b0, 32'h108);
    step("fwd_mem", 1'b1, 1'b1);
    mem_wen = 0; in_pc = 32'h10C;
    push_exp(32'hC, 32'h0, 1'b1, 5'd10, 1'b1, 1'b0, 32'h10C);
    step("fwd_wb", 1'b1, 1'b1);
    wb_enrd = 0; in_pc = 32'h110;
    push_exp(32'hD, 32'h0, 1'b1, 5'd10, 1'b1, 1'b0, 32'h110);
    step("fwd_rf", 1'b1, 1'b1);

    // Load-use stall then MEM forward
    drive(1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 32'h114);
    ex_wen = 1; ex_load = 1; ex_rdsel = 5'd3; ex_data = 32'hEE;
    step("ldu_stall", 1'b0, 1'b0);
    chk("ldu.stall_cnt", {16'd0, stall_cnt}, 32'd1);
    ex_wen = 0; ex_load = 0;
    mem_wen = 1; mem_rdsel = 5'd3; mem_data = 32'h55;
    push_exp(32'h0, 32'h55, 1'b1, 5'd11, 1'b1, 1'b1, 32'h114);
    step("ldu_mem", 1'b1, 1'b1);
    mem_wen = 0;

    // Unused source matching a load in EX: no stall
    drive(1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 5'd12, 1'b0, 1'b0, 32'h118);
    ex_wen = 1; ex_load = 1; ex_rdsel = 5'd3;
    push_exp(32'h0, 32'h0, 1'b0, 5'd12, 1'b0, 1'b0, 32'h118);
    step("unused", 1'b1, 1'b1);
    chk("unused.stall_cnt", {16'd0, stall_cnt}, 32'd1);
    ex_wen = 0; ex_load = 0;

    // Backpressure
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 32'h200);
    push_exp(32'h1234, 32'h0, 1'b1, 5'd13, 1'b1, 1'b0, 32'h200);
    step("bp_first", 1'b1, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd14, 1'b0, 1'b0, 32'h300);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 1'b0, 1'b1);
      chk("bp_hold.op1", out_op1, 32'h1234);
      chk("bp_hold.pc", out_pc, 32'h200);
      chk("bp_hold.rdsel", {27'd0, out_rdsel}, 32'd13);
    end
    out_ready = 1'b1;
    push_exp(32'hD, 32'h0, 1'b1, 5'd14, 1'b0, 1'b0, 32'h300);
    step("bp_release", 1'b1, 1'b1);

    // Flush with valid slot and incoming instruction
    out_ready = 1'b0; flush = 1'b1;
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 32'h400);
    step("flush", 1'b0, 1'b0);
    chk("flush.pc_hold", out_pc, 32'h300);
    flush = 1'b0; out_ready = 1'b1;
    push_exp(32'h1234, 32'h0, 1'b1, 5'd15, 1'b1, 1'b0, 32'h400);
    step("post_flush", 1'b1, 1'b1);

    // Reset while slot is held
    out_ready = 1'b0; reset = 1'b0;
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 32'h500);
    @(posedge clk);
    #1;
    chk("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.op1", out_op1, 32'd0);
    chk("rst2.pc", out_pc, 32'd0);
    chk("rst2.rdsel_wen", {26'd0, out_rdsel, out_wen}, 32'd0);
    chk("rst2.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b1; out_ready = 1'b1;

    // Hazard under flush is not counted
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 32'h600);
    ex_wen = 1; ex_load = 1; ex_rdsel = 5'd3;
    flush = 1'b1;
    step("hz_flush", 1'b0, 1'b0);
    chk("hz_flush.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    flush = 1'b0;

    // Saturation
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    step("sat_more", 1'b0, 1'b0);
    chk("sat_more.stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
